// File: rtl/shifter_pkg.sv
// Purpose: shared constants and pipeline payload type for the barrel-shifter front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shifter_pkg;

  localparam int DATA_W  = 4;
  localparam int SHAMT_W = 2;

  // Payload carried by both pipeline stages: the untouched word, its
  // normalising shift amount and the all-zero flag.
  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHAMT_W-1:0] shamt;
    logic               zero;
  } norm_pay_t;

endpackage

// File: rtl/norm_lzc4.sv
// Purpose: 4-bit leading-zero encoder giving the left shift that moves the leading one to bit 3.
// Latency: combinational.
// Backpressure: none (pure function of data).
// Ports:
//   data  - word to encode
//   shamt - number of leading zeros (0 when the word is all zero)
//   zero  - word is 4'b0000
module norm_lzc4
  import shifter_pkg::*;
(
  input  logic [DATA_W-1:0]  data,
  output logic [SHAMT_W-1:0] shamt,
  output logic               zero
);

  always_comb begin
    shamt = '0;
    zero  = 1'b0;
    casez (data)
      4'b1???: shamt = 2'd0;
      4'b01??: shamt = 2'd1;
      4'b001?: shamt = 2'd2;
      4'b0001: shamt = 2'd3;
      default: begin
        // All-zero word: nothing to normalise, flag it instead.
        shamt = 2'd0;
        zero  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/norm_shamt_gen.sv
// Purpose: accept 4-bit words, attach the normalising shift amount and zero flag, count normalised words.
// Latency: 2 register stages (accepted at edge N, out_valid after edge N+1); 1 word/cycle throughput.
// Backpressure: valid/ready; holds up to 2 words under stall, in_ready = s1 able to advance.
// Ports:
//   clk, rst            - clock, async active-high reset
//   in_valid/in_ready   - upstream handshake, in_data word
//   out_valid/out_ready - downstream handshake, out_a/out_shamt/out_zero payload
//   cnt_clr             - synchronous clear of norm_count (wins over increment)
//   norm_count          - saturating count of delivered words needing a non-zero shift
module norm_shamt_gen
  import shifter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_a,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic               out_zero,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   norm_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  norm_pay_t enc_pay;
  norm_pay_t s1_pay;
  norm_pay_t s2_pay;
  logic      s1_valid;
  logic      s2_valid;
  logic      s1_adv;
  logic      s2_adv;
  logic      out_xfer;

  norm_lzc4 u_lzc (
    .data  (in_data),
    .shamt (enc_pay.shamt),
    .zero  (enc_pay.zero)
  );
  assign enc_pay.data = in_data;

  // A stage may load when it is empty or its contents move on this edge.
  // Neither term looks at in_valid, so in_ready depends only on state and out_ready.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pay   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_pay <= enc_pay;
      end
    end
  end

  // S2 only reloads with a real word, so the output payload stays put
  // while the stage is stalled or empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_pay   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_pay <= s1_pay;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_a     = s2_pay.data;
  assign out_shamt = s2_pay.shamt;
  assign out_zero  = s2_pay.zero;

  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      norm_count <= '0;
    end else if (cnt_clr) begin
      norm_count <= '0;
    end else if (out_xfer && (s2_pay.shamt != '0) && !s2_pay.zero && (norm_count != CNT_MAX)) begin
      norm_count <= norm_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_norm_shamt_gen.sv
// Purpose: self-checking bench for norm_shamt_gen (default CNT_W and a CNT_W=2 copy on shared stimulus).
// Latency: n/a.
// Backpressure: n/a.
module tb_norm_shamt_gen;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;
  logic       cnt_clr;

  logic       in_ready, out_valid, out_zero;
  logic [3:0] out_a;
  logic [1:0] out_shamt;
  logic [7:0] norm_count;

  logic       in_ready2, out_valid2, out_zero2;
  logic [3:0] out_a2;
  logic [1:0] out_shamt2;
  logic [1:0] norm_count2;

  norm_shamt_gen #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_shamt(out_shamt),
    .out_zero(out_zero), .cnt_clr(cnt_clr), .norm_count(norm_count)
  );

  norm_shamt_gen #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_a(out_a2), .out_shamt(out_shamt2),
    .out_zero(out_zero2), .cnt_clr(cnt_clr), .norm_count(norm_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic [1:0] sh;
    logic       z;
    int         stamp;
  } ent_t;

  typedef struct {
    logic [3:0] d;
    logic [1:0] sh;
    logic       z;
  } vec_t;

  ent_t q[$];
  int   checks;
  int   failures;
  int   now;
  int   delivered;
  int   cnt8_m;
  int   cnt2_m;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Normalisation from first principles: double the word until bit 3 is set.
  task automatic ref_norm(input int w, output int sh, output bit z);
    int v;
    v  = w;
    sh = 0;
    z  = (w == 0);
    if (!z) begin
      while (v < 8) begin
        v  = v * 2;
        sh = sh + 1;
      end
    end
  endtask

  // One cycle: drive inputs on the falling edge, check outputs against the
  // queue model, then account for the transfers the next rising edge makes.
  task automatic step(input logic iv, input logic [3:0] id, input logic ordy,
                      input logic clr, input logic [1:0] esh, input logic ez);
    bit         exp_vld;
    bit         exp_rdy;
    bit         in_x;
    bit         out_x;
    ent_t       e;
    logic [3:0] t;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    cnt_clr   = clr;
    #1;
    // A word is visible once it has been through both register stages.
    exp_vld = (q.size() > 0) && (q[0].stamp <= now - 2);
    exp_rdy = (q.size() < 2) || ordy;
    chk("out_valid", out_valid, exp_vld);
    chk("out_valid_w2", out_valid2, exp_vld);
    chk("in_ready", in_ready, exp_rdy);
    chk("in_ready_w2", in_ready2, exp_rdy);
    if (exp_vld) begin
      chk("out_a", out_a, q[0].d);
      chk("out_shamt", out_shamt, q[0].sh);
      chk("out_zero", out_zero, q[0].z);
      chk("out_a_w2", out_a2, q[0].d);
      if (!out_zero) begin
        t = out_a << out_shamt;
        chk("norm_bit3", t[3], 1);
      end
    end
    chk("norm_count", norm_count, cnt8_m);
    chk("norm_count_w2", norm_count2, cnt2_m);
    out_x = exp_vld && ordy;
    in_x  = iv && exp_rdy;
    if (clr) begin
      cnt8_m = 0;
      cnt2_m = 0;
    end else if (out_x && (q[0].sh != 0) && !q[0].z) begin
      if (cnt8_m < 255) cnt8_m++;
      if (cnt2_m < 3) cnt2_m++;
    end
    if (out_x) begin
      void'(q.pop_front());
      delivered++;
    end
    if (in_x) begin
      e.d     = id;
      e.sh    = esh;
      e.z     = ez;
      e.stamp = now;
      q.push_back(e);
    end
    now++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'h9;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_norm_count", norm_count, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_out_valid", out_valid, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_shamt", out_shamt, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_norm_count_w2", norm_count2, 0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    q.delete();
    cnt8_m = 0;
    cnt2_m = 0;
  endtask

  vec_t tbl[9];
  int   sat_exp[5];

  initial begin
    int  sh;
    bit  z;
    int  d;
    int  cyc;
    int  base;
    bit  acc;
    bit  iv;
    bit  ordy;
    bit  clr;

    checks = 0; failures = 0; now = 0; delivered = 0; cnt8_m = 0; cnt2_m = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0; cnt_clr = 1'b0;

    tbl[0] = '{4'h8, 2'd0, 1'b0};
    tbl[1] = '{4'h5, 2'd1, 1'b0};
    tbl[2] = '{4'h3, 2'd2, 1'b0};
    tbl[3] = '{4'h1, 2'd3, 1'b0};
    tbl[4] = '{4'h0, 2'd0, 1'b1};
    tbl[5] = '{4'hf, 2'd0, 1'b0};
    tbl[6] = '{4'h7, 2'd1, 1'b0};
    tbl[7] = '{4'h2, 2'd2, 1'b0};
    tbl[8] = '{4'hc, 2'd0, 1'b0};
    sat_exp = '{1, 2, 3, 3, 3};

    // Reset with in_valid held, then first-word latency.
    do_reset();
    step(1'b1, 4'h4, 1'b1, 1'b0, 2'd1, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("lat_not_yet", out_valid, 0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("lat_visible", out_valid, 1);
    chk("lat_data", out_a, 4'h4);
    step(1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0);

    // Encode sweep, back-to-back.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, tbl[i].d, 1'b1, 1'b0, tbl[i].sh, tbl[i].z);
    repeat (3) step(1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("sweep_count", norm_count, 3);
    for (int i = 5; i < 9; i++) step(1'b1, tbl[i].d, 1'b1, 1'b0, tbl[i].sh, tbl[i].z);
    repeat (3) step(1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("sweep_count2", norm_count, 5);
    chk("sweep_empty", q.size(), 0);

    // Back-pressure: fill two stages, hold, then drain in order.
    base = delivered;
    step(1'b1, 4'h2, 1'b0, 1'b0, 2'd2, 1'b0);
    step(1'b1, 4'h4, 1'b0, 1'b0, 2'd1, 1'b0);
    repeat (3) begin
      step(1'b1, 4'h6, 1'b0, 1'b0, 2'd1, 1'b0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_a", out_a, 4'h2);
    end
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) begin
      step(1'b1, 4'h6, 1'b1, 1'b0, 2'd1, 1'b0);
      acc = in_ready;
    end
    chk("bp_accept_6", acc, 1);
    repeat (4) step(1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("bp_delivered", delivered - base, 3);

    // Saturation on the CNT_W=2 copy, then clear coincident with a transfer.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'h1, 1'b1, 1'b0, 2'd3, 1'b0);
      step(1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0);
      step(1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0);
      @(posedge clk);
      #1;
      chk("sat_count_w2", norm_count2, sat_exp[i]);
    end
    chk("sat_count_w8", norm_count, 5);
    step(1'b1, 4'h1, 1'b1, 1'b0, 2'd3, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("clr_wins_w2", norm_count2, 0);
    chk("clr_wins_w8", norm_count, 0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0);

    // Async reset between edges with two words in flight.
    step(1'b1, 4'ha, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 4'h3, 1'b0, 1'b0, 2'd2, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("inflight_valid", out_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_a", out_a, 0);
    chk("arst_in_ready", in_ready, 1);
    #1;
    rst = 1'b0;
    q.delete();
    cnt8_m = 0;
    cnt2_m = 0;
    repeat (5) step(1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0);

    // Random stall traffic against the queue model.
    do_reset();
    base = delivered;
    cyc  = 0;
    while ((delivered - base) < 1000 && cyc < 30000) begin
      iv   = ($urandom_range(0, 99) < 70);
      ordy = ($urandom_range(0, 99) < 60);
      clr  = ($urandom_range(0, 99) < 2);
      d    = $urandom_range(0, 15);
      ref_norm(d, sh, z);
      step(iv, 4'(d), ordy, clr, 2'(sh), z);
      cyc++;
    end
    chk("random_words_done", ((delivered - base) >= 1000) ? 1 : 0, 1);
    repeat (4) step(1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("random_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/norm_shamt_gen.md
Name: norm_shamt_gen

Overview:
Upstream stage of the 4-bit barrel shifter. It accepts 4-bit words over a valid/ready handshake and computes the left-shift amount that normalises each word (brings its leading one to bit 3). It presents the word and shift amount as A/ShAmt-ready outputs through a 2-stage elastic pipeline. It also flags all-zero words and keeps a saturating count of words that needed a non-zero shift.

Parameters:
CNT_W, 8, width of the norm_count statistics counter (minimum 1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word this cycle
in_data  input  4  word to normalise
out_valid  output  1  out_a/out_shamt/out_zero valid
out_ready  input  1  downstream (shifter consumer) accepts
out_a  output  4  word, unmodified, for shifter A input
out_shamt  output  2  normalising shift amount for shifter ShAmt input
out_zero  output  1  word was 4'b0000
cnt_clr  input  1  synchronous clear of norm_count
norm_count  output  CNT_W  saturating count of delivered words with out_shamt != 0 and out_zero = 0

Behaviour:
- Reset (async assert, sync-safe deassert by system): s1/s2 valid = 0, out_valid = 0, out_a = 0, out_shamt = 0, out_zero = 0, norm_count = 0. in_ready = 1 after reset.
- Handshakes: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready. Output data is held stable while out_valid & !out_ready. out_valid never drops without a transfer.
- Stage 1 (S1): registers in_data plus the combinational leading-zero encode:
  - 1xxx -> shamt 0
  - 01xx -> shamt 1
  - 001x -> shamt 2
  - 0001 -> shamt 3
  - 0000 -> shamt 0, zero = 1
- Stage 2 (S2): output registers, driving out_*.
- Advance rules:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv. in_ready is combinational from out_ready; no combinational path from in_valid to in_ready.
- Latency: word accepted at edge N appears on out_* after edge N+1 (out_valid high in cycle N+1, i.e. 2 register stages). Full throughput of 1 word/cycle while out_ready = 1.
- Back-pressure: with out_ready = 0, pipeline fills (2 words held), then in_ready = 0. Release of out_ready drains 1 word/cycle with no loss or duplication. Order is preserved.
- norm_count:
  - Increments by 1 on each output transfer with out_shamt != 0 & !out_zero.
  - Saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr = 1 forces 0 next edge; cnt_clr wins over a simultaneous increment.
- Reset mid-operation: all in-flight words discarded, outputs return to reset values immediately (async).

Decomposition:
- Shared package (shifter_pkg): SHAMT_W = 2, DATA_W = 4 constants, and a typedef for the {data, shamt, zero} pipeline payload, used by both stages.
- One natural sub-module: norm_lzc4 (combinational 4-bit leading-zero encoder giving shamt and zero). Pipeline control and counter stay in the top block.

Test Plan:
- Reset: assert rst with in_valid=1 -> out_valid=0, norm_count=0, in_ready=1; after release, first accepted word appears exactly 2 edges later.
- Encode sweep: stream 4'h8,4'h5,4'h3,4'h1,4'h0 with out_ready=1 -> (out_shamt,out_zero) = (0,0),(1,0),(2,0),(3,0),(0,1) back-to-back; norm_count ends at 3.
- Back-pressure: out_ready=0, offer 4'h2,4'h4,4'h6 -> in_ready drops after 2 accepts and out_a holds 4'h2 stable; raise out_ready -> 2,4,6 delivered in order, shamts 2,1,1.
- Random stall: random in_valid/out_ready over 1000 words vs scoreboard -> no loss, no duplication, order kept; out_a shifted by out_shamt always has bit3=1 unless out_zero.
- Saturation/clear: CNT_W=2, deliver 5 words of 4'h1 -> norm_count 1,2,3,3,3; cnt_clr coincident with a 6th 4'h1 transfer -> norm_count=0.
- Async reset mid-stream: rst pulse between edges with 2 words in flight -> out_valid=0 immediately; neither word is delivered after release.
